// File: rtl/video_mnist_frame_scheduler_if.sv
// AXI4-Stream video beat bundle shared by the frame scheduler's input and output sides.
// The master drives the beat and valid; the slave answers with ready.
interface video_mnist_frame_scheduler_if #(
    parameter int TUSER_WIDTH = 1,
    parameter int TDATA_WIDTH = 1
) ();
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tuser,
        output tlast,
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tuser,
        input  tlast,
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/video_mnist_frame_scheduler.sv
// Frame-admission gate in front of the MNIST CNN core: forwards whole frames only,
// decimates by param_skip_num, caps frames in flight, and swallows rejected frames.
module video_mnist_frame_scheduler #(
    parameter int TUSER_WIDTH  = 1,
    parameter int TDATA_WIDTH  = 1,
    parameter int IMG_Y_NUM    = 480,
    parameter int IMG_Y_WIDTH  = 10,
    parameter int SKIP_WIDTH   = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [SKIP_WIDTH-1:0] param_skip_num,
    video_mnist_frame_scheduler_if.slave  s_axi4s,
    video_mnist_frame_scheduler_if.master m_axi4s,
    input  logic                  mon_frame_done,
    output logic [2:0]            stat_inflight,
    output logic [STAT_WIDTH-1:0] stat_pass_count,
    output logic [STAT_WIDTH-1:0] stat_drop_count,
    output logic                  stat_short_frame
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [IMG_Y_WIDTH-1:0] LAST_LINE = IMG_Y_WIDTH'(IMG_Y_NUM - 1);
    localparam logic [2:0]             MAX_INF   = 3'(MAX_INFLIGHT);

    state_t                  state;
    state_t                  state_next;
    logic [IMG_Y_WIDTH-1:0]  line_cnt;
    logic [IMG_Y_WIDTH-1:0]  line_cnt_next;
    logic [IMG_Y_WIDTH-1:0]  line_base;
    logic [SKIP_WIDTH-1:0]   skip_cnt;
    logic [2:0]              inflight;
    logic [STAT_WIDTH-1:0]   pass_count;
    logic [STAT_WIDTH-1:0]   drop_count;
    logic                    short_frame;

    logic                    sof;
    logic                    admit;
    logic                    s_ready;
    logic                    m_valid;
    logic                    hs;
    logic                    sof_hs;
    logic                    line_hs;
    logic                    frame_end;
    logic                    inc;
    logic                    dec;
    logic [TUSER_WIDTH-1:0]  user;
    logic [TDATA_WIDTH-1:0]  pix;

    // Beat content passes straight through; only the handshake is gated.
    assign user           = s_axi4s.tuser;
    assign pix            = s_axi4s.tdata;
    assign m_axi4s.tuser  = user;
    assign m_axi4s.tdata  = pix;
    assign m_axi4s.tlast  = s_axi4s.tlast;
    assign m_axi4s.tvalid = m_valid;
    assign s_axi4s.tready = s_ready;

    assign sof   = s_axi4s.tvalid & user[0];
    assign admit = enable & (skip_cnt == '0) & (inflight < MAX_INF);

    assign hs     = s_axi4s.tvalid & s_ready;
    assign sof_hs = sof & hs;
    // A SOF beat that is also a line end counts as the first completed line.
    assign line_hs = hs & s_axi4s.tlast & (sof | (state != IDLE));
    assign line_base = sof ? '0 : line_cnt;
    assign frame_end = line_hs & (line_base == LAST_LINE);

    assign inc = sof_hs & admit;
    assign dec = mon_frame_done & (inflight != 3'd0);

    always_comb begin
        s_ready       = 1'b1;
        m_valid       = 1'b0;
        state_next    = state;
        line_cnt_next = line_cnt;

        // A SOF overrides whatever frame is in progress, so it is decided first.
        if (sof) begin
            if (admit) begin
                m_valid = s_axi4s.tvalid;
                s_ready = m_axi4s.tready;
            end
        end else if (state == PASS) begin
            m_valid = s_axi4s.tvalid;
            s_ready = m_axi4s.tready;
        end

        if (reset) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
        end

        if (frame_end) begin
            state_next    = IDLE;
            line_cnt_next = '0;
        end else if (line_hs) begin
            line_cnt_next = line_base + 1'b1;
            if (sof_hs) begin
                state_next = admit ? PASS : DROP;
            end
        end else if (sof_hs) begin
            state_next    = admit ? PASS : DROP;
            line_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            line_cnt <= '0;
        end else begin
            state    <= state_next;
            line_cnt <= line_cnt_next;
        end
    end

    // Decimation: an admitted frame reloads the skip budget, skipped SOFs burn it down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_cnt <= '0;
        end else if (sof_hs && enable) begin
            if (skip_cnt != '0) begin
                skip_cnt <= skip_cnt - 1'b1;
            end else if (inflight < MAX_INF) begin
                skip_cnt <= param_skip_num;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 3'd0;
        end else if (inc && !dec) begin
            inflight <= inflight + 3'd1;
        end else if (dec && !inc) begin
            inflight <= inflight - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_count  <= '0;
            drop_count  <= '0;
            short_frame <= 1'b0;
        end else begin
            if (inc) begin
                pass_count <= pass_count + 1'b1;
            end
            if (sof_hs && !admit) begin
                drop_count <= drop_count + 1'b1;
            end
            if (sof_hs && (state != IDLE)) begin
                short_frame <= 1'b1;
            end
        end
    end

    assign stat_inflight    = inflight;
    assign stat_pass_count  = pass_count;
    assign stat_drop_count  = drop_count;
    assign stat_short_frame = short_frame;

endmodule

// File: tb/tb_video_mnist_frame_scheduler.sv
// Randomized-data bench for the frame scheduler, checked against a frame-level admission model.
module tb_video_mnist_frame_scheduler;
    localparam int TUSER_WIDTH  = 1;
    localparam int TDATA_WIDTH  = 8;
    localparam int IMG_Y_NUM    = 4;
    localparam int IMG_Y_WIDTH  = 3;
    localparam int SKIP_WIDTH   = 4;
    localparam int MAX_INFLIGHT = 2;
    localparam int STAT_WIDTH   = 16;
    localparam int LINE_LEN     = 4;
    localparam int FRAME_BEATS  = IMG_Y_NUM * LINE_LEN;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic [SKIP_WIDTH-1:0] param_skip_num = '0;
    logic                  mon_frame_done = 1'b0;
    logic [2:0]            stat_inflight;
    logic [STAT_WIDTH-1:0] stat_pass_count;
    logic [STAT_WIDTH-1:0] stat_drop_count;
    logic                  stat_short_frame;

    video_mnist_frame_scheduler_if #(.TUSER_WIDTH(TUSER_WIDTH), .TDATA_WIDTH(TDATA_WIDTH)) s_if ();
    video_mnist_frame_scheduler_if #(.TUSER_WIDTH(TUSER_WIDTH), .TDATA_WIDTH(TDATA_WIDTH)) m_if ();

    video_mnist_frame_scheduler #(
        .TUSER_WIDTH (TUSER_WIDTH),
        .TDATA_WIDTH (TDATA_WIDTH),
        .IMG_Y_NUM   (IMG_Y_NUM),
        .IMG_Y_WIDTH (IMG_Y_WIDTH),
        .SKIP_WIDTH  (SKIP_WIDTH),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .STAT_WIDTH  (STAT_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .param_skip_num  (param_skip_num),
        .s_axi4s         (s_if),
        .m_axi4s         (m_if),
        .mon_frame_done  (mon_frame_done),
        .stat_inflight   (stat_inflight),
        .stat_pass_count (stat_pass_count),
        .stat_drop_count (stat_drop_count),
        .stat_short_frame(stat_short_frame)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Frame-level reference state.
    int skip_m = 0;
    int infl_m = 0;
    int pass_m = 0;
    int drop_m = 0;
    bit short_m = 0;
    bit mid_frame_m = 0;
    bit toggle = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         cmp_idx = 0;

    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready) begin
            got_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit model_sof();
        bit a;
        a = 1'b0;
        if (enable) begin
            if (skip_m != 0) begin
                skip_m--;
            end else if (infl_m < MAX_INFLIGHT) begin
                a = 1'b1;
                skip_m = int'(param_skip_num);
                infl_m++;
            end
        end
        if (a) pass_m++;
        else   drop_m++;
        return a;
    endfunction

    function automatic void model_done();
        if (infl_m > 0) infl_m--;
    endfunction

    function automatic void model_reset();
        skip_m = 0;
        infl_m = 0;
        pass_m = 0;
        drop_m = 0;
        short_m = 0;
        mid_frame_m = 0;
    endfunction

    // Presents one beat (entered #1 after a posedge) and holds it until accepted.
    task automatic send_beat(input logic u, input logic l, input logic [7:0] d,
                             input bit fwd, input bit done_hs);
        int n;
        bit hs;
        n = 0;
        hs = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tdata  = d;
        while (!hs && n < 64) begin
            if (toggle) m_if.tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("m_tvalid_gate", 32'(m_if.tvalid), 32'(fwd));
            if (toggle && fwd) check("s_tready_mirror", 32'(s_if.tready), 32'(m_if.tready));
            hs = s_if.tready;
            if (hs && done_hs) mon_frame_done = 1'b1;
            @(posedge clk);
            #1;
            mon_frame_done = 1'b0;
            n++;
        end
        if (!hs) check("beat_accept_timeout", 32'd0, 32'd1);
        if (fwd) exp_q.push_back({u, l, d});
        s_if.tvalid = 1'b0;
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int nbeats, input bit done_sof);
        bit adm;
        if (mid_frame_m) short_m = 1'b1;
        adm = model_sof();
        if (done_sof) model_done();
        for (int i = 0; i < nbeats; i++) begin
            send_beat(i == 0, (i % LINE_LEN) == LINE_LEN - 1, 8'($urandom),
                      adm, done_sof && i == 0);
        end
        mid_frame_m = (nbeats != FRAME_BEATS);
    endtask

    task automatic pulse_done();
        mon_frame_done = 1'b1;
        @(posedge clk);
        #1;
        mon_frame_done = 1'b0;
        model_done();
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_pass"}, 32'(stat_pass_count), 32'(pass_m % 65536));
        check({tag, "_drop"}, 32'(stat_drop_count), 32'(drop_m % 65536));
        check({tag, "_inflight"}, 32'(stat_inflight), 32'(infl_m));
        check({tag, "_short"}, 32'(stat_short_frame), 32'(short_m));
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_beat_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = cmp_idx; i < n; i++) begin
            check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        cmp_idx = n;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        enable      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset: a live SOF must still see no handshake.
        s_if.tvalid = 1'b1;
        s_if.tuser  = 1'b1;
        #1;
        check("reset_s_tready", 32'(s_if.tready), 32'd0);
        check("reset_m_tvalid", 32'(m_if.tvalid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        #1;
        check("idle_s_tready", 32'(s_if.tready), 32'd1);
        check_stats("reset");

        // T1: no decimation, each frame retired.
        param_skip_num = 4'd0;
        for (int f = 0; f < 3; f++) begin
            send_frame(FRAME_BEATS, 1'b0);
            pulse_done();
        end
        check_stream("t1");
        check_stats("t1");

        // T2: skip 2 keeps frames 0 and 3.
        param_skip_num = 4'd2;
        for (int f = 0; f < 6; f++) begin
            send_frame(FRAME_BEATS, 1'b0);
            pulse_done();
        end
        param_skip_num = 4'd0;
        check_stream("t2");
        check_stats("t2");

        // T3: in-flight cap without retirement.
        for (int f = 0; f < 3; f++) send_frame(FRAME_BEATS, 1'b0);
        check_stream("t3a");
        check_stats("t3a");
        pulse_done();
        send_frame(FRAME_BEATS, 1'b0);
        check_stream("t3b");
        check_stats("t3b");
        pulse_done();
        pulse_done();

        // T4: downstream backpressure.
        toggle = 1'b1;
        send_frame(FRAME_BEATS, 1'b0);
        send_frame(FRAME_BEATS, 1'b0);
        toggle = 1'b0;
        m_if.tready = 1'b1;
        check_stream("t4");
        pulse_done();
        pulse_done();
        check_stats("t4");

        // T5: short frame, then done coincident with an admit.
        send_frame(2 * LINE_LEN, 1'b0);
        send_frame(FRAME_BEATS, 1'b0);
        check_stream("t5a");
        check_stats("t5a");
        pulse_done();
        send_frame(FRAME_BEATS, 1'b1);
        check_stream("t5b");
        check_stats("t5b");
        pulse_done();

        // Disabled: SOF consumed and counted as dropped.
        enable = 1'b0;
        send_frame(FRAME_BEATS, 1'b0);
        enable = 1'b1;
        check_stream("disabled");
        check_stats("disabled");

        // T6: reset in the middle of a forwarded frame.
        send_frame(6, 1'b0);
        check_stream("t6a");
        s_if.tvalid = 1'b1;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_reset_s_tready", 32'(s_if.tready), 32'd0);
        check("t6_reset_m_tvalid", 32'(m_if.tvalid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        s_if.tvalid = 1'b0;
        model_reset();
        #1;
        check_stats("t6_after_reset");
        for (int i = 6; i < FRAME_BEATS; i++) begin
            send_beat(1'b0, (i % LINE_LEN) == LINE_LEN - 1, 8'($urandom), 1'b0, 1'b0);
        end
        send_frame(FRAME_BEATS, 1'b0);
        check_stream("t6b");
        check_stats("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
